// File: rtl/gpio_in_debounce.sv
// Switch/button input port: 2-flop synchronisers, tick-sampled debounce, sticky
// press/change event flags with clear-on-read, registered read port and level irq.
module gpio_in_debounce #(
  parameter int SW_WIDTH        = 18,
  parameter int KEY_WIDTH       = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk_div8,
  input  logic                  rst_n,
  input  logic [SW_WIDTH-1:0]   sw_in,
  input  logic [KEY_WIDTH-1:0]  key_n_in,
  input  logic                  rd_en,
  input  logic                  rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  irq
);

  localparam int IN_W = SW_WIDTH + KEY_WIDTH;

  logic [SW_WIDTH-1:0]   sw_meta_q, sw_sync_q;
  logic [KEY_WIDTH-1:0]  key_meta_q, key_sync_q;
  logic [IN_W-1:0]       synced, diff;
  logic [IN_W-1:0]       samp_q, samp_d, stable_q, stable_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  tick;
  logic [KEY_WIDTH-1:0]  key_evt_q, key_evt_d, key_set, key_clr;
  logic                  sw_chg_q, sw_chg_d, sw_set, sw_clr, rd_clr;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, irq_q, irq_d;

  // Stable/sample vectors are laid out {key, sw} so the level word is a plain copy.
  assign synced = {~key_sync_q, sw_sync_q};

  always_comb begin
    tick  = (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_WIDTH'(1);

    diff     = synced ^ samp_q;
    samp_d   = samp_q;
    stable_d = stable_q;
    if (tick) begin
      samp_d   = synced;
      stable_d = (synced & ~diff) | (stable_q & diff);
    end

    key_set = stable_d[IN_W-1:SW_WIDTH] & ~stable_q[IN_W-1:SW_WIDTH];
    sw_set  = |(stable_d[SW_WIDTH-1:0] ^ stable_q[SW_WIDTH-1:0]);

    // A flag setting in the clearing cycle survives; it was not in the returned word.
    rd_clr    = rd_en & rd_sel;
    key_clr   = rd_clr ? key_evt_q : '0;
    sw_clr    = rd_clr & sw_chg_q;
    key_evt_d = (key_evt_q & ~key_clr) | key_set;
    sw_chg_d  = (sw_chg_q & ~sw_clr) | sw_set;

    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_sel ? DATA_WIDTH'({sw_chg_q, key_evt_q}) : DATA_WIDTH'(stable_q);
    end

    irq_d = sw_chg_q | (|key_evt_q);
  end

  always_ff @(posedge clk_div8 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
      cnt_q      <= '0;
      samp_q     <= '0;
      stable_q   <= '0;
      key_evt_q  <= '0;
      sw_chg_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_n_in;
      key_sync_q <= key_meta_q;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      stable_q   <= stable_d;
      key_evt_q  <= key_evt_d;
      sw_chg_q   <= sw_chg_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed + randomized bench for gpio_in_debounce with a settled-pin reference model
// of levels and sticky events; expectations follow pin history, not RTL internals.
module tb_gpio_in_debounce;

  localparam int SW_W = 18;
  localparam int KEY_W = 3;
  localparam int DW = 32;
  localparam int DB = 4;

  logic            clk_div8 = 1'b0;
  logic            rst_n = 1'b0;
  logic [SW_W-1:0] sw_in = '0;
  logic [KEY_W-1:0] key_n_in = '1;
  logic            rd_en = 1'b0;
  logic            rd_sel = 1'b0;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            irq;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  // reference model: settled pin levels and sticky flags
  logic [SW_W-1:0]  sw_m = '0;
  logic [KEY_W-1:0] key_m = '0;
  logic             chg_m = 1'b0;
  logic [KEY_W-1:0] kevt_m = '0;

  gpio_in_debounce #(
    .SW_WIDTH(SW_W), .KEY_WIDTH(KEY_W), .DATA_WIDTH(DW),
    .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(16)
  ) dut (
    .clk_div8(clk_div8), .rst_n(rst_n), .sw_in(sw_in), .key_n_in(key_n_in),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
  );

  always #5 clk_div8 = ~clk_div8;

  // Edges since reset release; the prescaler ticks on every DB-th edge.
  always @(posedge clk_div8 or negedge rst_n)
    if (!rst_n) edges <= 0;
    else edges <= edges + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_div8);
  endtask

  function automatic logic [DW-1:0] level_word();
    return DW'({key_m, sw_m});
  endfunction

  function automatic logic [DW-1:0] event_word();
    return DW'({chg_m, kevt_m});
  endfunction

  // Drive pins, wait well past sync + two ticks, then fold the change into the model.
  task automatic settle(input logic [SW_W-1:0] sw_v, input logic [KEY_W-1:0] key_pressed);
    sw_in    = sw_v;
    key_n_in = ~key_pressed;
    step(14);
    if (sw_v != sw_m) chg_m = 1'b1;
    kevt_m = kevt_m | (key_pressed & ~key_m);
    sw_m   = sw_v;
    key_m  = key_pressed;
  endtask

  task automatic do_read(input logic sel, input string tag);
    logic [DW-1:0] exp;
    exp = sel ? event_word() : level_word();
    rd_en  = 1'b1;
    rd_sel = sel;
    @(negedge clk_div8);
    rd_en = 1'b0;
    check({tag, "_valid"}, DW'(rd_valid), 32'd1);
    check(tag, rd_data, exp);
    if (sel) begin
      chg_m  = 1'b0;
      kevt_m = '0;
    end
    $display("read sel=%0d tag=%s data=0x%08h", sel, tag, rd_data);
  endtask

  task automatic check_irq(input string tag);
    step(2);
    check(tag, DW'(irq), DW'(chg_m | (|kevt_m)));
  endtask

  initial begin
    logic [DW-1:0] exp_lvl, exp_evt, exp_lvl2;
    logic [SW_W-1:0] rsw;
    logic [KEY_W-1:0] rkey;

    step(2);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_valid", DW'(rd_valid), 32'd0);
    check("rst_irq", DW'(irq), 32'd0);
    rst_n = 1'b1;
    step(2);
    check("post_rst_valid", DW'(rd_valid), 32'd0);
    do_read(1'b0, "rst_level");

    // switch pattern, event read, irq falls after clear
    settle(18'h2A5A5, 3'b000);
    check_irq("sw_irq_set");
    do_read(1'b0, "sw_level");
    check("sw_level_abs", rd_data, 32'h0002A5A5);
    do_read(1'b1, "sw_event");
    check("sw_event_abs", rd_data, 32'h8);
    check_irq("sw_irq_clr");

    // short glitch on key 1 must be rejected
    key_n_in[1] = 1'b0;
    step(3);
    key_n_in[1] = 1'b1;
    step(14);
    check("glitch_irq", DW'(irq), 32'd0);
    do_read(1'b0, "glitch_level");
    do_read(1'b1, "glitch_event");

    // key 0 press
    settle(18'h2A5A5, 3'b001);
    check_irq("key0_irq");
    do_read(1'b0, "key0_level");
    check("key0_bit18", DW'(rd_data[18]), 32'd1);
    do_read(1'b1, "key0_event");
    check("key0_event_abs", rd_data, 32'h1);
    do_read(1'b1, "key0_event2");
    check_irq("key0_irq_clr");

    // collision: key 2 press accepted on the same edge that an event read clears key 0
    settle(18'h2A5A5, 3'b000);
    settle(18'h2A5A5, 3'b001);
    while (edges % DB != 0) @(negedge clk_div8);
    key_n_in[2] = 1'b0;
    step(7);
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    @(negedge clk_div8);
    rd_en = 1'b0;
    check("coll_valid", DW'(rd_valid), 32'd1);
    check("coll_first", rd_data, 32'h1);
    $display("read sel=1 tag=coll_first data=0x%08h", rd_data);
    key_m  = 3'b101;
    chg_m  = 1'b0;
    kevt_m = 3'b100;
    step(12);
    check_irq("coll_irq");
    do_read(1'b1, "coll_second");
    check("coll_second_abs", rd_data, 32'h4);

    // randomized settled changes against the model
    for (int i = 0; i < 24; i++) begin
      rsw  = SW_W'($urandom);
      rkey = KEY_W'($urandom);
      if (i % 5 == 0) rsw = sw_m;
      settle(rsw, rkey);
      check_irq("rnd_irq");
      do_read(1'b0, "rnd_level");
      do_read(1'b1, "rnd_event");
      check_irq("rnd_irq_clr");
    end

    // back-to-back burst level/event/level
    settle(sw_m ^ 18'h00F0F, key_m);
    exp_lvl = level_word();
    exp_evt = event_word();
    rd_en = 1'b1; rd_sel = 1'b0;
    @(negedge clk_div8);
    check("burst0_valid", DW'(rd_valid), 32'd1);
    check("burst0_data", rd_data, exp_lvl);
    rd_sel = 1'b1;
    @(negedge clk_div8);
    check("burst1_valid", DW'(rd_valid), 32'd1);
    check("burst1_data", rd_data, exp_evt);
    chg_m = 1'b0; kevt_m = '0;
    rd_sel = 1'b0;
    @(negedge clk_div8);
    rd_en = 1'b0;
    check("burst2_valid", DW'(rd_valid), 32'd1);
    check("burst2_data", rd_data, exp_lvl);
    @(negedge clk_div8);
    check("burst_end_valid", DW'(rd_valid), 32'd0);
    check("burst_hold_data", rd_data, exp_lvl);
    $display("burst levels=0x%08h events=0x%08h", exp_lvl, exp_evt);

    // async reset mid-burst with an event pending
    settle(sw_m ^ 18'h30000, key_m);
    check_irq("pre_rst_irq");
    rd_en = 1'b1; rd_sel = 1'b0;
    @(negedge clk_div8);
    check("pre_rst_valid", DW'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data", rd_data, 32'd0);
    check("mid_rst_valid", DW'(rd_valid), 32'd0);
    check("mid_rst_irq", DW'(irq), 32'd0);
    @(negedge clk_div8);
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_div8);
    check("post_rst2_valid", DW'(rd_valid), 32'd0);
    exp_lvl2 = level_word();
    sw_m = '0; key_m = '0; chg_m = 1'b0; kevt_m = '0;
    settle(exp_lvl2[SW_W-1:0], exp_lvl2[SW_W+KEY_W-1:SW_W]);
    do_read(1'b0, "post_rst2_level");
    do_read(1'b1, "post_rst2_event");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
